// File: rtl/cvt_pkg.sv
// cvt_pkg: shared widths and FSM state type for the 16-to-9 bit repacker.
//   IN_W  - input word width
//   OUT_W - output word width
//   BUF_W - bit buffer width
//   CNT_W - width of the buffered-bit counter (holds 0..25)
//   VB_W  - width of the output valid-bits field (holds 0..9)
package cvt_pkg;

  localparam int IN_W  = 16;
  localparam int OUT_W = 9;
  localparam int BUF_W = 32;
  localparam int CNT_W = 5;
  localparam int VB_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/cvt16to9.sv
// cvt16to9: repacks a packetised MSB-first bit stream carried in 16-bit
// words (each with 0..16 valid bits) into 9-bit words, without losing or
// reordering bits. The last output word of a packet carries the remainder.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   data_in[15:0]       input word, valid bits MSB-aligned
//   data_in_valid       input word present
//   data_in_valid_bits  valid bits in data_in (17..31 treated as 16)
//   data_in_sop/eop     first / last word of input packet
//   data_in_ready       input word accepted on valid && ready
//   data_out[8:0]       output word, MSB-aligned, unused low bits 0
//   data_out_valid      output word present
//   data_out_valid_bits valid bits in data_out (0..9)
//   data_out_sop/eop    first / last word of output packet
//   data_out_ready      downstream accepts on valid && ready
module cvt16to9
  import cvt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   data_in,
  input  logic              data_in_valid,
  input  logic [4:0]        data_in_valid_bits,
  input  logic              data_in_sop,
  input  logic              data_in_eop,
  output logic              data_in_ready,
  output logic [OUT_W-1:0]  data_out,
  output logic              data_out_valid,
  output logic [VB_W-1:0]   data_out_valid_bits,
  output logic              data_out_sop,
  output logic              data_out_eop,
  input  logic              data_out_ready
);

  state_t             r_state;
  logic [BUF_W-1:0]   r_buf;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_first;      // next emitted word is the packet's first
  logic [OUT_W-1:0]   r_dout;
  logic [VB_W-1:0]    r_dvb;
  logic               r_dval;
  logic               r_dsop;
  logic               r_deop;

  logic [CNT_W-1:0]   w_vb;
  logic [IN_W-1:0]    w_mask;
  logic [IN_W-1:0]    w_word;
  logic [BUF_W-1:0]   w_aligned;
  logic [BUF_W-1:0]   w_appended;
  logic               w_ready;
  logic               w_accept;
  logic               w_emit_full;
  logic               w_emit_last;
  logic               w_load;

  always_comb begin
    w_vb       = (data_in_valid_bits > 5'd16) ? 5'd16 : data_in_valid_bits;
    // Clear bits below the valid count so the buffer stays zero beneath cnt;
    // this is what keeps unused low bits of the final word at 0.
    w_mask     = ~(16'hFFFF >> w_vb);
    w_word     = data_in & w_mask;
    w_aligned  = {w_word, {(BUF_W-IN_W){1'b0}}};
    w_appended = r_buf | (w_aligned >> r_cnt);

    w_ready = 1'b0;
    case (r_state)
      ST_IDLE:  w_ready = 1'b1;
      ST_RUN:   w_ready = (r_cnt <= 5'd9);
      default:  w_ready = 1'b0;
    endcase

    w_accept    = data_in_valid && w_ready;
    w_emit_full = ((r_state == ST_RUN) && (r_cnt >= 5'd10)) ||
                  ((r_state == ST_FLUSH) && (r_cnt > 5'd9));
    w_emit_last = (r_state == ST_FLUSH) && (r_cnt <= 5'd9);
    w_load      = (!r_dval || data_out_ready) && (w_emit_full || w_emit_last);
  end

  // Accept only happens in IDLE or in RUN with cnt<=9; loads only happen in
  // RUN with cnt>=10 or in FLUSH, so the two branches never fire together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_first <= 1'b0;
      r_dout  <= '0;
      r_dvb   <= '0;
      r_dval  <= 1'b0;
      r_dsop  <= 1'b0;
      r_deop  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_state == ST_IDLE) begin
          // Words arriving in IDLE without sop are dropped.
          if (data_in_sop) begin
            r_buf   <= w_aligned;
            r_cnt   <= w_vb;
            r_first <= 1'b1;
            r_state <= data_in_eop ? ST_FLUSH : ST_RUN;
          end
        end else begin
          r_buf <= w_appended;
          r_cnt <= r_cnt + w_vb;
          if (data_in_eop) begin
            r_state <= ST_FLUSH;
          end
        end
      end

      if (w_load) begin
        r_dout  <= r_buf[BUF_W-1 -: OUT_W];
        r_dval  <= 1'b1;
        r_dsop  <= r_first;
        r_first <= 1'b0;
        if (w_emit_full) begin
          r_buf  <= r_buf << OUT_W;
          r_cnt  <= r_cnt - 5'd9;
          r_dvb  <= 4'd9;
          r_deop <= 1'b0;
        end else begin
          r_dvb   <= r_cnt[VB_W-1:0];
          r_deop  <= 1'b1;
          r_buf   <= '0;
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      end else if (r_dval && data_out_ready) begin
        r_dval <= 1'b0;
      end
    end
  end

  assign data_in_ready       = w_ready;
  assign data_out            = r_dout;
  assign data_out_valid      = r_dval;
  assign data_out_valid_bits = r_dvb;
  assign data_out_sop        = r_dsop;
  assign data_out_eop        = r_deop;

endmodule

// File: tb/tb_cvt16to9.sv
// tb_cvt16to9: directed-vector bench for cvt16to9. Output words are
// collected by a monitor and compared against hand-computed streams.
module tb_cvt16to9;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        data_in_valid;
  logic [4:0]  data_in_valid_bits;
  logic        data_in_sop;
  logic        data_in_eop;
  logic        data_in_ready;
  logic [8:0]  data_out;
  logic        data_out_valid;
  logic [3:0]  data_out_valid_bits;
  logic        data_out_sop;
  logic        data_out_eop;
  logic        data_out_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [14:0] mon_q[$];
  logic [14:0] exp_q[$];

  cvt16to9 dut (
    .clk                (clk),
    .rst                (rst),
    .data_in            (data_in),
    .data_in_valid      (data_in_valid),
    .data_in_valid_bits (data_in_valid_bits),
    .data_in_sop        (data_in_sop),
    .data_in_eop        (data_in_eop),
    .data_in_ready      (data_in_ready),
    .data_out           (data_out),
    .data_out_valid     (data_out_valid),
    .data_out_valid_bits(data_out_valid_bits),
    .data_out_sop       (data_out_sop),
    .data_out_eop       (data_out_eop),
    .data_out_ready     (data_out_ready)
  );

  always #5 clk = ~clk;

  // {sop, eop, vb[3:0], data[8:0]}
  function automatic logic [14:0] ow(input logic s, input logic e,
                                     input logic [3:0] vb, input logic [8:0] d);
    return {s, e, vb, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transfers are committed at the next rising edge; sample mid-cycle.
  always @(negedge clk) begin
    if (!rst && data_out_valid && data_out_ready) begin
      mon_q.push_back({data_out_sop, data_out_eop, data_out_valid_bits, data_out});
      $display("out: data=0x%03h vb=%0d sop=%0b eop=%0b",
               data_out, data_out_valid_bits, data_out_sop, data_out_eop);
    end
  end

  task automatic send(input logic [15:0] d, input logic [4:0] vb,
                      input logic s, input logic e);
    int n = 0;
    bit done = 1'b0;
    data_in            = d;
    data_in_valid_bits = vb;
    data_in_sop        = s;
    data_in_eop        = e;
    data_in_valid      = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (data_in_ready) done = 1'b1;
      @(posedge clk); #1;
      n++;
      if (!done && n > 50) begin
        chk("send_timeout", 32'(n), 32'd50);
        done = 1'b1;
      end
    end
    $display("in:  data=0x%04h vb=%0d sop=%0b eop=%0b", d, vb, s, e);
    data_in_valid = 1'b0;
    data_in_sop   = 1'b0;
    data_in_eop   = 1'b0;
  endtask

  task automatic check_stream(input string name);
    repeat (40) @(posedge clk);
    #1;
    chk($sformatf("%s_count", name), 32'(mon_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < mon_q.size())
        chk($sformatf("%s_word%0d", name, i), 32'(mon_q[i]), 32'(exp_q[i]));
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic exp_p32();
    exp_q.push_back(ow(1'b1, 1'b0, 4'd9, 9'h157));
    exp_q.push_back(ow(1'b0, 1'b1, 4'd7, 9'h134));
  endtask

  task automatic exp_p33();
    exp_q.push_back(ow(1'b1, 1'b0, 4'd9, 9'h1FF));
    exp_q.push_back(ow(1'b0, 1'b0, 4'd9, 9'h1FC));
    exp_q.push_back(ow(1'b0, 1'b0, 4'd9, 9'h000));
    exp_q.push_back(ow(1'b0, 1'b1, 4'd5, 9'h000));
  endtask

  initial begin
    int n;
    rst                = 1'b1;
    data_in            = '0;
    data_in_valid      = 1'b0;
    data_in_valid_bits = '0;
    data_in_sop        = 1'b0;
    data_in_eop        = 1'b0;
    data_out_ready     = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready",  32'(data_in_ready), 32'd1);
    chk("rst_out_valid", 32'(data_out_valid), 32'd0);
    chk("rst_out_fields",
        32'({data_out_sop, data_out_eop, data_out_valid_bits, data_out}), 32'd0);
    @(posedge clk); #1;

    // Single-word packet, 16 bits
    send(16'hABCD, 5'd16, 1'b1, 1'b1);
    exp_p32();
    check_stream("p32");

    // Two-word packet
    send(16'hFFFF, 5'd16, 1'b1, 1'b0);
    send(16'h0000, 5'd16, 1'b0, 1'b1);
    exp_p33();
    check_stream("p33");

    // Downstream stall with the output register full
    data_out_ready = 1'b0;
    send(16'hFFFF, 5'd16, 1'b1, 1'b0);
    send(16'h0000, 5'd16, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_fields", i),
          32'({data_out_valid, data_out_sop, data_out_eop, data_out_valid_bits, data_out}),
          32'({1'b1, ow(1'b1, 1'b0, 4'd9, 9'h1FF)}));
      chk($sformatf("stall%0d_in_ready", i), 32'(data_in_ready), 32'd0);
    end
    @(posedge clk); #1;
    data_out_ready = 1'b1;
    exp_p33();
    check_stream("stall");

    // Zero-bit packet
    send(16'hFFFF, 5'd0, 1'b1, 1'b1);
    exp_q.push_back(ow(1'b1, 1'b1, 4'd0, 9'h000));
    check_stream("zero");

    // Reset in mid-packet after the first output word
    send(16'hFFFF, 5'd16, 1'b1, 1'b0);
    send(16'h0000, 5'd16, 1'b0, 1'b1);
    n = 0;
    while (mon_q.size() < 1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midrst_first_seen", 32'(mon_q.size() >= 1), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(data_out_valid), 32'd0);
    chk("midrst_in_ready",  32'(data_in_ready), 32'd1);
    @(posedge clk); #1;
    send(16'hABCD, 5'd16, 1'b1, 1'b1);
    exp_p32();
    check_stream("midrst");

    // Word without sop while idle is dropped
    send(16'h1234, 5'd16, 1'b0, 1'b0);
    send(16'hABCD, 5'd16, 1'b1, 1'b1);
    exp_p32();
    check_stream("nosop");

    // Oversized valid-bits count behaves as 16
    send(16'hABCD, 5'd31, 1'b1, 1'b1);
    exp_p32();
    check_stream("vb31");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
